// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared sizes and requester indices for the register-file write-back path.
// ALU, LSU and CSR results share one register-file write port.
package parameters;

    localparam int MSB        = 31;
    localparam int LSB        = 0;
    localparam int NUM_WB_SRC = 3;
    localparam int REG_ADDR_W = 5;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: the most recent grantee drops to lowest priority.
// The grant is purely combinational from req and the stored pointer.
module rr_arbiter
    import parameters::*;
#(
    parameter int NREQ = NUM_WB_SRC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] last;
    logic [PW-1:0] winner;
    logic [PW-1:0] idx;
    logic          found;

    // Scan last+1, last+2, ..., last and take the first requester found.
    always_comb begin
        grant  = '0;
        winner = last;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx;
                found      = 1'b1;
            end
        end
        if (!rst_n) begin
            grant = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= PW'(NREQ - 1);
        end else if (|grant) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates requesters onto the register-file write
// port through a one-cycle output stage and tracks pending writes for decode.
module regfile_wb_ctrl
    import parameters::*;
#(
    parameter int NREQ = NUM_WB_SRC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                wb_valid,
    input  logic [NREQ*REG_ADDR_W-1:0]     wb_rd,
    input  logic [NREQ*(MSB-LSB+1)-1:0]    wb_data,
    output logic [NREQ-1:0]                wb_ready,
    output logic [REG_ADDR_W-1:0]          rf_rd,
    output logic [MSB:LSB]                 rf_regdata,
    output logic                           rf_wer,
    input  logic                           iss_valid,
    input  logic [REG_ADDR_W-1:0]          iss_rd,
    input  logic [REG_ADDR_W-1:0]          chk_rs1,
    input  logic [REG_ADDR_W-1:0]          chk_rs2,
    input  logic [REG_ADDR_W-1:0]          chk_rd,
    output logic                           hazard,
    output logic [31:0]                    busy
);

    localparam int DW = MSB - LSB + 1;

    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [MSB:LSB]        sel_data;
    logic [31:0]           busy_r;
    logic [31:0]           busy_next;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wb_valid),
        .grant (wb_ready)
    );

    assign xfer = |(wb_valid & wb_ready);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wb_ready[i]) begin
                sel_rd   = wb_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = wb_data[i*DW +: DW];
            end
        end
    end

    // Writes to x0 are consumed like any other but never enable the port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wer     <= 1'b0;
            rf_rd      <= '0;
            rf_regdata <= '0;
        end else if (xfer) begin
            rf_wer     <= (sel_rd != '0);
            rf_rd      <= sel_rd;
            rf_regdata <= sel_data;
        end else begin
            rf_wer     <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle issue to the same register wins.
    always_comb begin
        busy_next = busy_r;
        if (rf_wer) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (iss_valid) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next;
        end
    end

    assign busy   = busy_r;
    assign hazard = busy_r[chk_rs1] | busy_r[chk_rs2] | busy_r[chk_rd];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: a per-cycle vector table plus short
// hand-written sequences for fairness and scoreboard clear latency.
module tb_regfile_wb_ctrl;

    import parameters::*;

    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] CF = 32'hCAFE_F00D;
    localparam logic [31:0] D9 = 32'h9999_9999;
    localparam logic [31:0] D4 = 32'h4444_4444;

    logic        clk;
    logic        rst_n;
    logic [2:0]  wb_valid;
    logic [14:0] wb_rd;
    logic [95:0] wb_data;
    logic [2:0]  wb_ready;
    logic [4:0]  rf_rd;
    logic [31:0] rf_regdata;
    logic        rf_wer;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic [31:0] busy;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst_n;
        logic [2:0]  valid;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] d0, d1, d2;
        logic        iv;
        logic [4:0]  ird, rs1, rs2, crd;
        logic [2:0]  e_ready;
        logic        e_wer;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_haz;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[22];

    regfile_wb_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .rf_rd      (rf_rd),
        .rf_regdata (rf_regdata),
        .rf_wer     (rf_wer),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .hazard     (hazard),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n     = v.rst_n;
        wb_valid  = v.valid;
        wb_rd     = {v.rd2, v.rd1, v.rd0};
        wb_data   = {v.d2, v.d1, v.d0};
        iss_valid = v.iv;
        iss_rd    = v.ird;
        chk_rs1   = v.rs1;
        chk_rs2   = v.rs2;
        chk_rd    = v.crd;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; wb_valid = '0; wb_rd = '0; wb_data = '0;
        iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ptr;
        int expIdx;
        int prevIdx;
        logic got;

        //          rst  valid   rd0   rd1   rd2   d0      d1            d2   iv   ird    rs1    rs2    crd     ready   wer   rfrd  rfdata        haz   busy
        vecs[0]  = '{1'b1,3'b111,5'd1, 5'd2, 5'd3, D1,     D2,           D3,  1'b0,5'd0,  5'd0,  5'd0,  5'd0,   3'b001,1'b0,5'd0, 32'h0,        1'b0,32'h0};
        vecs[1]  = '{1'b1,3'b111,5'd1, 5'd2, 5'd3, D1,     D2,           D3,  1'b0,5'd0,  5'd0,  5'd0,  5'd0,   3'b010,1'b1,5'd1, D1,           1'b0,32'h0};
        vecs[2]  = '{1'b1,3'b111,5'd1, 5'd2, 5'd3, D1,     D2,           D3,  1'b0,5'd0,  5'd0,  5'd0,  5'd0,   3'b100,1'b1,5'd2, D2,           1'b0,32'h0};
        vecs[3]  = '{1'b1,3'b111,5'd1, 5'd2, 5'd3, D1,     D2,           D3,  1'b0,5'd0,  5'd0,  5'd0,  5'd0,   3'b001,1'b1,5'd3, D3,           1'b0,32'h0};
        vecs[4]  = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b0,5'd0, 5'd0,  5'd0,  5'd0,   3'b000,1'b1,5'd1, D1,           1'b0,32'h0};
        vecs[5]  = '{1'b1,3'b001,5'd5, 5'd0, 5'd0, DB,     32'h0,        32'h0,1'b0,5'd0, 5'd0,  5'd0,  5'd0,   3'b001,1'b0,5'd1, D1,           1'b0,32'h0};
        vecs[6]  = '{1'b1,3'b010,5'd0, 5'd0, 5'd0, 32'h0,  32'h1234,     32'h0,1'b0,5'd0, 5'd0,  5'd0,  5'd0,   3'b010,1'b1,5'd5, DB,           1'b0,32'h0};
        vecs[7]  = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b0,5'd0, 5'd0,  5'd0,  5'd0,   3'b000,1'b0,5'd0, 32'h1234,     1'b0,32'h0};
        vecs[8]  = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b1,5'd7, 5'd0,  5'd0,  5'd0,   3'b000,1'b0,5'd0, 32'h1234,     1'b0,32'h0};
        vecs[9]  = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b0,5'd0, 5'd7,  5'd0,  5'd0,   3'b000,1'b0,5'd0, 32'h1234,     1'b1,32'h80};
        vecs[10] = '{1'b1,3'b001,5'd7, 5'd0, 5'd0, CF,     32'h0,        32'h0,1'b0,5'd0, 5'd7,  5'd0,  5'd0,   3'b001,1'b0,5'd0, 32'h1234,     1'b1,32'h80};
        vecs[11] = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b0,5'd0, 5'd7,  5'd0,  5'd0,   3'b000,1'b1,5'd7, CF,           1'b1,32'h80};
        vecs[12] = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b0,5'd0, 5'd7,  5'd0,  5'd0,   3'b000,1'b0,5'd7, CF,           1'b0,32'h0};
        vecs[13] = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b1,5'd0, 5'd0,  5'd0,  5'd0,   3'b000,1'b0,5'd7, CF,           1'b0,32'h0};
        vecs[14] = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b1,5'd12,5'd0,  5'd0,  5'd0,   3'b000,1'b0,5'd7, CF,           1'b0,32'h0};
        vecs[15] = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b0,5'd0, 5'd0,  5'd12, 5'd0,   3'b000,1'b0,5'd7, CF,           1'b1,32'h1000};
        vecs[16] = '{1'b1,3'b100,5'd0, 5'd0, 5'd9, 32'h0,  32'h0,        D9,  1'b0,5'd0,  5'd3,  5'd0,  5'd12,  3'b100,1'b0,5'd7, CF,           1'b1,32'h1000};
        vecs[17] = '{1'b1,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b1,5'd9, 5'd0,  5'd0,  5'd12,  3'b000,1'b1,5'd9, D9,           1'b1,32'h1000};
        vecs[18] = '{1'b1,3'b001,5'd4, 5'd0, 5'd0, D4,     32'h0,        32'h0,1'b0,5'd0, 5'd9,  5'd0,  5'd0,   3'b001,1'b0,5'd9, D9,           1'b1,32'h1200};
        vecs[19] = '{1'b0,3'b111,5'd1, 5'd2, 5'd3, D1,     D2,           D3,  1'b0,5'd0,  5'd0,  5'd0,  5'd0,   3'b000,1'b1,5'd4, D4,           1'b0,32'h1200};
        vecs[20] = '{1'b0,3'b000,5'd0, 5'd0, 5'd0, 32'h0,  32'h0,        32'h0,1'b0,5'd0, 5'd0,  5'd0,  5'd0,   3'b000,1'b0,5'd0, 32'h0,        1'b0,32'h0};
        vecs[21] = '{1'b1,3'b111,5'd1, 5'd2, 5'd3, D1,     D2,           D3,  1'b0,5'd0,  5'd0,  5'd0,  5'd0,   3'b001,1'b0,5'd0, 32'h0,        1'b0,32'h0};

        rst_n = 1'b0; wb_valid = '0; wb_rd = '0; wb_data = '0;
        iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        repeat (2) @(negedge clk);
        wb_valid = 3'b111;
        #1;
        checkOutput("reset.ready",  32'(wb_ready),   32'h0);
        checkOutput("reset.wer",    32'(rf_wer),     32'h0);
        checkOutput("reset.rd",     32'(rf_rd),      32'h0);
        checkOutput("reset.data",   rf_regdata,      32'h0);
        checkOutput("reset.busy",   busy,            32'h0);
        checkOutput("reset.hazard", 32'(hazard),     32'h0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.ready", i),  32'(wb_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("v%0d.wer", i),    32'(rf_wer),   32'(vecs[i].e_wer));
            checkOutput($sformatf("v%0d.rd", i),     32'(rf_rd),    32'(vecs[i].e_rd));
            checkOutput($sformatf("v%0d.data", i),   rf_regdata,    vecs[i].e_data);
            checkOutput($sformatf("v%0d.hazard", i), 32'(hazard),   32'(vecs[i].e_haz));
            checkOutput($sformatf("v%0d.busy", i),   busy,          vecs[i].e_busy);
        end

        // Scoreboard clear latency: transfer in N, write in N+1, clear seen in N+2.
        doReset();
        iss_valid = 1'b1; iss_rd = 5'd20;
        @(negedge clk);
        iss_valid = 1'b0; iss_rd = '0; chk_rs1 = 5'd20;
        wb_valid = 3'b001; wb_rd = {5'd0, 5'd0, 5'd20}; wb_data = {32'h0, 32'h0, 32'h2020_2020};
        #1;
        checkOutput("seqC.hazard_set", 32'(hazard), 32'h1);
        checkOutput("seqC.busy_set",   busy,        32'h0010_0000);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (wb_ready[0]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checkOutput("seqC.grant_wait", 32'(got), 32'h1);
        @(negedge clk);
        wb_valid = '0;
        #1;
        checkOutput("seqC.wer",        32'(rf_wer),  32'h1);
        checkOutput("seqC.rd",         32'(rf_rd),   32'd20);
        checkOutput("seqC.data",       rf_regdata,   32'h2020_2020);
        checkOutput("seqC.hazard_wr",  32'(hazard),  32'h1);
        @(negedge clk);
        #1;
        checkOutput("seqC.hazard_clr", 32'(hazard),  32'h0);
        checkOutput("seqC.busy_clr",   busy,         32'h0);

        // Continuous contention: model rotates the pointer independently.
        doReset();
        wb_valid = 3'b111; wb_rd = {5'd3, 5'd2, 5'd1}; wb_data = {D3, D2, D1};
        ptr = 2;
        prevIdx = -1;
        for (int c = 0; c < 6; c++) begin
            #1;
            expIdx = (ptr + 1) % 3;
            checkOutput($sformatf("seqB.c%0d.grant", c), 32'(wb_ready), 32'(3'b001 << expIdx));
            checkOutput($sformatf("seqB.c%0d.wer", c), 32'(rf_wer), (prevIdx < 0) ? 32'h0 : 32'h1);
            if (prevIdx >= 0) begin
                checkOutput($sformatf("seqB.c%0d.rd", c), 32'(rf_rd), 32'(prevIdx + 1));
            end
            prevIdx = expIdx;
            ptr = expIdx;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32x32 register file. It arbitrates three write-back requesters (ALU, LSU, CSR) round-robin onto the single register-file write port and registers the winner for one cycle. It also keeps a 32-bit pending-write scoreboard so decode can stall on RAW and WAW hazards. It sits between the execute/memory units and the register file's `rd`/`regdata`/`wer` inputs, and beside the decode stage.

## Interface
Parameters:
- `NREQ`, 3 (from package `NUM_WB_SRC`): number of write-back requesters; index 0 = ALU, 1 = LSU, 2 = CSR.
- `MSB`/`LSB`, from package `parameters`: data width bounds, 31/0.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wb_valid`  in  NREQ  requester i holds a result.
- `wb_rd`  in  NREQ x 5  destination register per requester.
- `wb_data`  in  NREQ x (MSB-LSB+1)  result per requester.
- `wb_ready`  out  NREQ  grant; one-hot or zero.
- `rf_rd`  out  5  register-file write address.
- `rf_regdata`  out  32  register-file write data.
- `rf_wer`  out  1  register-file write enable.
- `iss_valid`  in  1  decode issues an instruction that writes `iss_rd`.
- `iss_rd`  in  5  destination of the issuing instruction.
- `chk_rs1`, `chk_rs2`, `chk_rd`  in  5 each  operands of the instruction in decode.
- `hazard`  out  1  decode must stall.
- `busy`  out  32  scoreboard, for debug.

## Operation
- Handshake: a transfer occurs on requester i when `wb_valid[i] && wb_ready[i]`. A requester holds `wb_valid`, `wb_rd` and `wb_data` stable until its transfer. `wb_ready` is combinational from `wb_valid` and the RR pointer; it never depends on `wb_ready`.
- Arbitration: the pointer `last` holds the most recent grantee. Priority order is `last+1`, `last+2`, `last` (mod 3). The pointer updates only in cycles with a transfer. If no requester is valid, no grant is made.
- Output stage: a transfer in cycle N loads `rf_rd`/`rf_regdata` and sets `rf_wer=1` in cycle N+1. The register file commits at the end of N+1.
  - With no transfer, `rf_wer=0`; `rf_rd`/`rf_regdata` hold their last values.
  - A transfer with `wb_rd==0` is consumed, but `rf_wer` stays 0.
  - One write per cycle, so the stage never backpressures beyond arbitration.
- Scoreboard, `busy[31:0]`; `busy[0]` is constant 0:
  - Set: `busy[iss_rd]` on `iss_valid && iss_rd!=0`.
  - Clear: `busy[rf_rd]` at the end of a cycle with `rf_wer=1`.
  - Set and clear of the same index in the same cycle: set wins.
- Hazard (combinational): `hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]`. Index 0 is never busy.
  - The write-cycle register read returns old data, so `busy` stays set through the `rf_wer` cycle. There is no bypass.
  - The `chk_rd` term blocks WAW, which guarantees at most one outstanding writer per register.
- The block does not check `hazard` before honouring `iss_valid`; decode must not assert `iss_valid` while `hazard`.

## Timing
- Reset (at a `clk` edge with `rst_n=0`): `rf_wer=0`, `rf_rd=0`, `rf_regdata=0`, `busy=0`, `last=2` (ALU first priority). `wb_ready` is 0 while `rst_n=0`.
- Reset mid-operation discards any in-flight write and all pending scoreboard bits. Upstream units are reset together.
- Latency: transfer to register-file commit is 1 cycle. Transfer to `busy` clear is visible in cycle N+2.
- Throughput: one write-back per cycle. Under continuous contention, each requester is served at least once every 3 cycles.

## Structure
- Package `parameters` holds `MSB`, `LSB`, `NUM_WB_SRC=3`, `REG_ADDR_W=5`, and the requester index constants `WB_ALU=0`, `WB_LSU=1`, `WB_CSR=2`.
- One sub-module, `rr_arbiter`: an NREQ-way round-robin arbiter with `clk`, `rst_n`, `req`, `grant`, and a pointer update on `|grant`.
- The output register and the scoreboard live in the top module.

## Test plan
- Reset, then only ALU valid with rd=5, data=0xDEADBEEF → `wb_ready=3'b001` in cycle 0; in cycle 1, `rf_wer=1`, `rf_rd=5`, `rf_regdata=0xDEADBEEF`.
- All three valid continuously (rd 1/2/3) → grant order ALU, LSU, CSR, ALU…; `rf_rd` sequence 1,2,3,1 from cycle 1.
- LSU valid with rd=0, data=0x1234 → `wb_ready[1]=1` for one cycle, then `rf_wer` stays 0.
- `iss_valid` with rd=7, then `chk_rs1=7` → `hazard=1` until ALU writes rd 7; `hazard` drops in the cycle after `rf_wer=1`, `rf_rd=7`.
- Same-cycle `iss_valid`, `iss_rd=9` with `rf_wer=1`, `rf_rd=9` → `busy[9]=1` afterwards. Then assert `rst_n=0` with `busy` nonzero → `busy=0`, `rf_wer=0` the next cycle.
